// File: rtl/s1_cfg_loader_if.sv
// Host-side configuration stream: one 4-bit mux word per cell, valid/ready handshake.
// The loader publishes the index of the cell the next accepted word will configure.
interface s1_cfg_loader_if #(
    parameter int IDX_W = 3
) ();
    logic             cfg_valid;
    logic [3:0]       cfg_data;
    logic             cfg_ready;
    logic [IDX_W-1:0] cfg_idx;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready,
        input  cfg_idx
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready,
        output cfg_idx
    );
endinterface

// File: rtl/s1_cfg_loader.sv
// Loads one mux word per S1 cell into a shadow buffer, commits all of them at once
// to the cell array and releases the array from clear.
//
//   state  | meaning
//   IDLE   | cells cleared, waiting for start
//   LOAD   | accepting words into shadow, cells cleared
//   COMMIT | single cycle, shadow copied to cfg_lut at its closing edge
//   RUN    | cells enabled with committed config
module s1_cfg_loader #(
    parameter int NUM_CELLS = 8,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic                   clk_i,
    input  logic                   clr_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    s1_cfg_loader_if.slave         cfg,
    output logic [4*NUM_CELLS-1:0] cfg_lut_o,
    output logic                   cell_clr_o,
    output logic                   cell_en_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_CELLS-1:0][3:0]   shadow_q, shadow_d;
    logic [4*NUM_CELLS-1:0]      lut_q, lut_d;
    logic                        err_q, err_d;
    logic                        ready;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            lut_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            lut_q    <= lut_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        lut_d    = lut_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE, RUN: begin
                if (start_i) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                // abort takes priority, so the word offered alongside it is dropped
                if (abort_i) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    err_d   = 1'b1;
                end else if (cfg.cfg_valid) begin
                    shadow_d[idx_q] = cfg.cfg_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = COMMIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            COMMIT: begin
                lut_d   = shadow_q;
                state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        cell_clr_o = 1'b1;
        cell_en_o  = 1'b0;
        unique case (state_q)
            LOAD: begin
                ready  = 1'b1;
                busy_o = 1'b1;
            end
            COMMIT: busy_o = 1'b1;
            RUN: begin
                done_o     = 1'b1;
                cell_clr_o = 1'b0;
                cell_en_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_idx   = idx_q;
    assign cfg_lut_o     = lut_q;
    assign err_o         = err_q;

endmodule
